// File: rtl/shape_cmd_arbiter.sv
// rtl/shape_cmd_arbiter.sv - round-robin command arbiter for the shape processor control SFR

// Shape processor register model types shared by the arbiter and its bench.
package shape_processor_modeling;

  typedef enum logic [2:0] {
    KEEP_SHAPE  = 3'd0,
    CIRCLE      = 3'd1,
    RECTANGLE   = 3'd2,
    TRIANGLE    = 3'd3,
    SHAPE_RSVD4 = 3'd4,
    SHAPE_RSVD5 = 3'd5,
    SHAPE_RSVD6 = 3'd6,
    SHAPE_RSVD7 = 3'd7
  } shape_e;

  typedef enum logic [1:0] {
    KEEP_OPERATION = 2'd0,
    AREA           = 2'd1,
    PERIMETER      = 2'd2,
    OPERATION_RSVD = 2'd3
  } operation_e;

  // Control SFR image: SHAPE in the low bits, OPERATION above it, rest reserved.
  typedef struct packed {
    logic [26:0] reserved;
    operation_e  OPERATION;
    shape_e      SHAPE;
  } ctrl_sfr_reg;

endpackage

module shape_cmd_arbiter
  import shape_processor_modeling::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][$bits(shape_e)-1:0] req_shape,
  input  logic [NUM_REQ-1:0][$bits(operation_e)-1:0] req_operation,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  output logic                                   rsp_error,
  output logic [$bits(shape_e)-1:0]              rsp_shape,
  output logic [$bits(operation_e)-1:0]          rsp_operation,
  output logic                                   busy,
  output logic                                   write,
  output logic [31:0]                            write_data,
  output logic                                   read,
  input  logic [31:0]                            read_data,
  input  logic                                   error
);

  localparam int SW = $bits(shape_e);
  localparam int OW = $bits(operation_e);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [SW-1:0] shape_q;
  logic [OW-1:0] operation_q;
  logic          err_q;
  logic [SW-1:0] rb_shape;
  logic [OW-1:0] rb_operation;

  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic          accept;

  ctrl_sfr_reg   wr_image;
  ctrl_sfr_reg   rd_image;
  logic          shape_mismatch;
  logic          operation_mismatch;
  logic          unused_rd_bits;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  // A grant is only offered from IDLE and never while reset is held.
  assign accept = (state == S_IDLE) && grant_found && rst_n;

  // One-hot ready strobe to the granted requester.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Command FSM: accept, write once, read back once, respond once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state <= S_WRITE;
        S_WRITE: state <= S_READ;
        S_READ:  state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latch the winning command fields at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= '0;
      shape_q     <= '0;
      operation_q <= '0;
    end else if (accept) begin
      owner       <= grant_idx;
      shape_q     <= req_shape[grant_idx];
      operation_q <= req_operation[grant_idx];
    end
  end

  // Capture the write rejection flag during the write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == S_WRITE) begin
      err_q <= error;
    end
  end

  // Capture the SFR read-back; these registers also drive the response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_shape     <= '0;
      rb_operation <= '0;
    end else if (state == S_READ) begin
      rb_shape     <= rd_image.SHAPE;
      rb_operation <= rd_image.OPERATION;
    end
  end

  // Advance the round-robin pointer past the owner once its response is sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (state == S_RESP) begin
      rr_ptr <= (owner == LAST_IDX) ? '0 : owner + IW'(1);
    end
  end

  // SFR image for the write: only SHAPE and OPERATION populated.
  always_comb begin
    wr_image           = '0;
    wr_image.SHAPE     = shape_e'(shape_q);
    wr_image.OPERATION = operation_e'(operation_q);
  end

  assign rd_image       = ctrl_sfr_reg'(read_data);
  assign unused_rd_bits = ^rd_image.reserved;

  // KEEP_* fields are not expected to change the SFR, so they cannot mismatch.
  assign shape_mismatch     = (shape_q != SW'(KEEP_SHAPE)) && (rb_shape != shape_q);
  assign operation_mismatch = (operation_q != OW'(KEEP_OPERATION)) && (rb_operation != operation_q);

  // Bus strobes and response outputs decoded from the current state.
  always_comb begin
    write      = (state == S_WRITE);
    write_data = (state == S_WRITE) ? 32'(wr_image) : 32'd0;
    read       = (state == S_READ);
    busy       = (state != S_IDLE);
    rsp_valid  = '0;
    rsp_error  = 1'b0;
    if (state == S_RESP) begin
      rsp_valid[owner] = 1'b1;
      rsp_error        = err_q | shape_mismatch | operation_mismatch;
    end
  end

  assign rsp_shape     = rb_shape;
  assign rsp_operation = rb_operation;

endmodule

// File: tb/tb_shape_cmd_arbiter.sv
// tb/tb_shape_cmd_arbiter.sv - directed self-checking bench for shape_cmd_arbiter

module tb_shape_cmd_arbiter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0][2:0]  req_shape;
  logic [1:0][1:0]  req_operation;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic             rsp_error;
  logic [2:0]       rsp_shape;
  logic [1:0]       rsp_operation;
  logic             busy;
  logic             write;
  logic [31:0]      write_data;
  logic             read;
  logic [31:0]      read_data;
  logic             error;

  int checks = 0;
  int errors = 0;

  shape_cmd_arbiter #(.NUM_REQ(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_shape     (req_shape),
    .req_operation (req_operation),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_error     (rsp_error),
    .rsp_shape     (rsp_shape),
    .rsp_operation (rsp_operation),
    .busy          (busy),
    .write         (write),
    .write_data    (write_data),
    .read          (read),
    .read_data     (read_data),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one command through IDLE/WRITE/READ/RESP; entered #1 after a posedge in IDLE.
  task automatic run_cmd(input int own, input logic [31:0] img, input logic [31:0] rb,
                         input logic err_in, input logic exp_err, input logic hold);
    logic [1:0] onehot;
    onehot = 2'b01 << own;
    @(negedge clk);
    chk("accept_ready", 32'(req_ready), 32'(onehot));
    chk("accept_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    if (!hold) req_valid = 2'b00;
    error = err_in;
    @(negedge clk);
    chk("write_strobe", 32'(write), 32'd1);
    chk("write_data", write_data, img);
    chk("write_busy", 32'(busy), 32'd1);
    chk("write_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    error = 1'b0;
    read_data = rb;
    @(negedge clk);
    chk("read_strobe", 32'(read), 32'd1);
    chk("read_write_low", 32'(write), 32'd0);
    chk("read_wdata_zero", write_data, 32'd0);
    chk("read_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    read_data = 32'h5555_5555;
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(onehot));
    chk("rsp_error", 32'(rsp_error), 32'(exp_err));
    chk("rsp_shape", 32'(rsp_shape), 32'(rb[2:0]));
    chk("rsp_operation", 32'(rsp_operation), 32'(rb[4:3]));
    chk("rsp_busy", 32'(busy), 32'd1);
    chk("rsp_read_low", 32'(read), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    req_valid     = 2'b00;
    req_shape     = '0;
    req_operation = '0;
    read_data     = 32'd0;
    error         = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_shape", 32'(rsp_shape), 32'd0);
    chk("rst_rsp_operation", 32'(rsp_operation), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_read", 32'(read), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Legal command from requester 0: CIRCLE/AREA -> image 0x09
    req_shape[0] = 3'd1; req_operation[0] = 2'd1; req_valid = 2'b01;
    run_cmd(0, 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_rsp_valid_low", 32'(rsp_valid), 32'd0);
    chk("idle_rsp_shape_hold", 32'(rsp_shape), 32'd1);
    @(posedge clk); #1;

    // Rejected command from requester 1: RECTANGLE/PERIMETER, SFR still CIRCLE/AREA
    req_shape[1] = 3'd2; req_operation[1] = 2'd2; req_valid = 2'b10;
    run_cmd(1, 32'h0000_0012, 32'h0000_0009, 1'b1, 1'b1, 1'b0);

    // KEEP_SHAPE + PERIMETER, SFR applies it: RECTANGLE/PERIMETER read back
    req_shape[0] = 3'd0; req_operation[0] = 2'd2; req_valid = 2'b01;
    run_cmd(0, 32'h0000_0010, 32'h0000_0012, 1'b0, 1'b0, 1'b0);

    // Same command, SFR left at RECTANGLE/AREA -> operation mismatch
    req_shape[1] = 3'd0; req_operation[1] = 2'd2; req_valid = 2'b10;
    run_cmd(1, 32'h0000_0010, 32'h0000_000A, 1'b0, 1'b1, 1'b0);

    // Both requesters held valid: grants 0,1,0,1
    req_shape[0] = 3'd3; req_operation[0] = 2'd1;
    req_shape[1] = 3'd1; req_operation[1] = 2'd2;
    req_valid = 2'b11;
    run_cmd(0, 32'h0000_000B, 32'h0000_000B, 1'b0, 1'b0, 1'b1);
    run_cmd(1, 32'h0000_0011, 32'hFFFF_FF11, 1'b0, 1'b0, 1'b1);
    run_cmd(0, 32'h0000_000B, 32'h0000_000B, 1'b0, 1'b0, 1'b1);
    run_cmd(1, 32'h0000_0011, 32'h0000_0011, 1'b0, 1'b0, 1'b1);

    // Reset during READ with requester 1 as owner
    req_shape[1] = 3'd2; req_operation[1] = 2'd1; req_valid = 2'b10;
    @(negedge clk);
    chk("mid_accept_ready", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_shape[0] = 3'd1; req_operation[0] = 2'd1; req_valid = 2'b11;
    @(negedge clk);
    chk("mid_write_data", write_data, 32'h0000_000A);
    @(posedge clk); #1;
    read_data = 32'h0000_000A;
    @(negedge clk);
    chk("mid_read", 32'(read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_read", 32'(read), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    #2;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    run_cmd(0, 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shape_cmd_arbiter.md
# shape_cmd_arbiter

Shares the shape processor control SFR between NUM_REQ command sources. Each command (shape, operation) is accepted through a valid/ready handshake, arbitrated round-robin, issued as a single bus write and confirmed by a read-back of the SFR. The requester receives a one-cycle response carrying the read-back fields and an error flag. The block sits between the requesters and the shape_processor write/read/error bus and uses the shape_processor_modeling package types (shape_e, operation_e, ctrl_sfr_reg).

## Interface
- NUM_REQ, default 2: number of requesters, legal range 2..8.
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester command valid.
- req_shape  input  NUM_REQ x $bits(shape_e)  per-requester SHAPE field; KEEP_SHAPE allowed.
- req_operation  input  NUM_REQ x $bits(operation_e)  per-requester OPERATION field; KEEP_OPERATION allowed.
- req_ready  output  NUM_REQ  one-hot accept strobe.
- rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe to the command owner.
- rsp_error  output  1  command failed; qualified by any rsp_valid bit.
- rsp_shape  output  $bits(shape_e)  SHAPE read back after the command; qualified by rsp_valid.
- rsp_operation  output  $bits(operation_e)  OPERATION read back after the command; qualified by rsp_valid.
- busy  output  1  high in every state other than IDLE.
- write  output  1  shape processor write strobe.
- write_data  output  32  ctrl_sfr_reg image to be written.
- read  output  1  shape processor read strobe.
- read_data  input  32  SFR read data; valid in the same cycle as read.
- error  input  1  write rejected; valid in the same cycle as write.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE
  - If any req_valid bit is set, select the winner: the first set bit at or after rr_ptr, searching upward modulo NUM_REQ.
  - Drive req_ready[winner]=1 combinationally in this cycle.
  - Latch owner, shape and operation; go to WRITE.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- WRITE
  - write=1 for exactly one cycle.
  - write_data = ctrl_sfr_reg with SHAPE/OPERATION set to the latched fields and all other bits 0.
  - err_q <= error; go to READ.
- READ
  - read=1 for exactly one cycle.
  - Latch read_data.SHAPE and read_data.OPERATION; go to RESP.
- RESP
  - rsp_valid[owner]=1 for one cycle, with the read-back fields on rsp_shape/rsp_operation.
  - rsp_error = err_q OR (latched shape != KEEP_SHAPE AND readback shape != latched shape) OR (latched operation != KEEP_OPERATION AND readback operation != latched operation).
  - rr_ptr <= (owner+1) mod NUM_REQ; go to IDLE.
- Handshake rules
  - Transfer occurs on req_valid && req_ready.
  - A requester holds its fields stable while req_valid is high and may drop req_valid at any time before acceptance.
  - req_ready is never asserted outside IDLE.
  - Commands are never queued internally: at most one is in flight.
- No value filtering is done here. Reserved, illegal-combination and KEEP_* commands are forwarded unchanged, and the shape processor decides acceptance.
- Outside WRITE, write_data=0. Outside READ, read=0. Outside RESP, rsp_valid=0 and rsp_error=0; rsp_shape/rsp_operation hold their last value.

## Timing
- Cycle N (IDLE): accept.
- Cycle N+1: write.
- Cycle N+2: read.
- Cycle N+3: rsp_valid.
- The next accept occurs at cycle N+4 at the earliest. Peak throughput is one command per 4 cycles.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 commands.
- Simultaneous req_valid from all sources after reset: index 0 wins first, then 1, 2, and so on. rr_ptr wraps from NUM_REQ-1 to 0.
- Reset values of all outputs: req_ready, rsp_valid, rsp_error, rsp_shape, rsp_operation, busy, write, write_data, read are all 0. rr_ptr=0, state=IDLE.
- Reset asserted mid-command:
  - The in-flight command is dropped with no response.
  - write/read deassert asynchronously.
  - After rst_n rises, the FSM restarts in IDLE with rr_ptr=0.
- A req_valid that deasserts in the same cycle it would be granted is not accepted. Grant is combinational on the current req_valid, so a low bit is never granted.

## Test plan
- Legal command, requester 0 (CIRCLE, AREA), error=0, readback CIRCLE/AREA:
  - req_ready[0] at N, write at N+1 with the packed image, read at N+2.
  - rsp_valid[0] at N+3 with rsp_error=0 and rsp_shape=CIRCLE, rsp_operation=AREA.
- Rejected command: error=1 during write, SFR unchanged.
  - rsp_error=1; rsp fields equal the previous SFR contents.
- KEEP_SHAPE with operation PERIMETER over an SFR holding (RECTANGLE, AREA):
  - Readback RECTANGLE/PERIMETER gives rsp_error=0.
  - Readback RECTANGLE/AREA gives rsp_error=1.
- All NUM_REQ=2 requesters held valid for 4 commands:
  - Grant order 0,1,0,1; each response goes to the correct owner; busy stays high except the IDLE accept cycles.
- rst_n pulsed low during READ:
  - read and busy drop immediately; no rsp_valid is produced.
  - The next accept goes to requester 0 even if requester 1 was the in-flight owner.
